max_pool_2x2_stream: RTL and testbench

Streaming 2×2, stride-2 max-pool engine for post-activation feature maps, sitting between the expand stage and the output writer. Pixels arrive in raster order, one beat per pixel, each beat carrying LANES independent channel words. The block buffers one row of horizontal pair-maxima and emits the 2×2 window maximum per lane, under valid/ready flow control. A per-frame mode selects pooling or transparent bypass.

---
 rtl/max_pool_2x2_stream_if.sv | 34 +++
 rtl/max_pool_2x2_stream.sv | 134 +++++++++++++
 tb/tb_max_pool_2x2_stream.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/max_pool_2x2_stream_if.sv
// Stream and control bundle for the 2x2 max-pool engine.
// The slave modport is the engine's view; the master modport is the producer/consumer side.
interface max_pool_2x2_stream_if #(
    parameter int LANES    = 4,
    parameter int DATA_W   = 12,
    parameter int MAX_COLS = 64,
    parameter int MAX_ROWS = 64
);
    localparam int CW = $clog2(MAX_COLS + 1);
    localparam int RW = $clog2(MAX_ROWS + 1);

    logic                      start_i;
    logic [CW-1:0]             cfg_cols_i;
    logic [RW-1:0]             cfg_rows_i;
    logic                      max_en_i;
    logic [LANES*DATA_W-1:0]   data_i;
    logic                      valid_i;
    logic                      ready_o;
    logic [LANES*DATA_W-1:0]   data_o;
    logic                      valid_o;
    logic                      ready_i;
    logic                      busy_o;
    logic                      done_o;

    modport slave (
        input  start_i, cfg_cols_i, cfg_rows_i, max_en_i, data_i, valid_i, ready_i,
        output ready_o, data_o, valid_o, busy_o, done_o
    );

    modport master (
        output start_i, cfg_cols_i, cfg_rows_i, max_en_i, data_i, valid_i, ready_i,
        input  ready_o, data_o, valid_o, busy_o, done_o
    );
endinterface

// File: rtl/max_pool_2x2_stream.sv
// Streaming 2x2 stride-2 max-pool with per-frame bypass, one row of pair-maxima buffered,
// and a single output register giving bubble-free valid/ready flow.
module max_pool_2x2_stream #(
    parameter int LANES    = 4,
    parameter int DATA_W   = 12,
    parameter int MAX_COLS = 64,
    parameter int MAX_ROWS = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    max_pool_2x2_stream_if.slave  bus
);
    localparam int CW     = $clog2(MAX_COLS + 1);
    localparam int RW     = $clog2(MAX_ROWS + 1);
    localparam int W      = LANES * DATA_W;
    localparam int LDEPTH = MAX_COLS / 2;
    localparam int LW     = (LDEPTH > 1) ? $clog2(LDEPTH) : 1;
    localparam logic [W-1:0] MAG_MASK = {LANES{{1'b0, {(DATA_W-1){1'b1}}}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          r_state, w_nextState;
    logic [CW-1:0]   r_cols, r_col, w_cfgCols;
    logic [RW-1:0]   r_rows, r_row, w_cfgRows;
    logic            r_maxEn;
    logic [W-1:0]    r_pair, r_data;
    logic            r_valid;
    logic [W-1:0]    r_line [LDEPTH];
    logic [W-1:0]    w_h, w_pool, w_lineWord, w_loadData;
    logic [LW-1:0]   w_lineIdx;
    logic            w_ready, w_accept, w_colLast, w_rowLast, w_load, w_lineWr;

    // Magnitude-only compare; the sign/pad bit never influences the winner.
    function automatic logic [DATA_W-1:0] pickMax(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        return (a[DATA_W-2:0] >= b[DATA_W-2:0]) ? a : b;
    endfunction

    always_comb begin
        w_cfgCols = bus.cfg_cols_i;
        if (bus.cfg_cols_i == '0)
            w_cfgCols = CW'(1);
        else if (bus.cfg_cols_i > CW'(MAX_COLS))
            w_cfgCols = CW'(MAX_COLS);
        w_cfgRows = bus.cfg_rows_i;
        if (bus.cfg_rows_i == '0)
            w_cfgRows = RW'(1);
        else if (bus.cfg_rows_i > RW'(MAX_ROWS))
            w_cfgRows = RW'(MAX_ROWS);
    end

    assign w_ready    = (r_state == RUN) & (~r_valid | bus.ready_i);
    assign w_accept   = bus.valid_i & w_ready;
    assign w_colLast  = (r_col == r_cols - 1'b1);
    assign w_rowLast  = (r_row == r_rows - 1'b1);
    assign w_lineIdx  = r_col[LW:1];
    assign w_lineWord = r_line[w_lineIdx];
    assign w_load     = w_accept & (~r_maxEn | (r_col[0] & r_row[0]));
    assign w_lineWr   = w_accept & r_maxEn & r_col[0] & ~r_row[0];

    always_comb begin
        w_h    = '0;
        w_pool = '0;
        for (int k = 0; k < LANES; k++) begin
            w_h[k*DATA_W +: DATA_W]    = pickMax(r_pair[k*DATA_W +: DATA_W],
                                                 bus.data_i[k*DATA_W +: DATA_W]);
            w_pool[k*DATA_W +: DATA_W] = pickMax(w_h[k*DATA_W +: DATA_W],
                                                 w_lineWord[k*DATA_W +: DATA_W]);
        end
    end

    assign w_loadData = r_maxEn ? (w_pool & MAG_MASK) : bus.data_i;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (bus.start_i) w_nextState = RUN;
            RUN:     if (w_accept & w_colLast & w_rowLast) w_nextState = DRAIN;
            DRAIN:   if (~r_valid) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_cols  <= '0;
            r_rows  <= '0;
            r_maxEn <= 1'b0;
            r_col   <= '0;
            r_row   <= '0;
            r_pair  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == IDLE && bus.start_i) begin
                r_cols  <= w_cfgCols;
                r_rows  <= w_cfgRows;
                r_maxEn <= bus.max_en_i;
                r_col   <= '0;
                r_row   <= '0;
            end else if (w_accept) begin
                if (w_colLast) begin
                    r_col <= '0;
                    r_row <= w_rowLast ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
                if (~r_col[0])
                    r_pair <= bus.data_i;
            end
            // Load and take on the same edge keeps valid high with fresh data.
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= w_loadData;
            end else if (bus.ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    // Stale entries are harmless: each even row rewrites an entry before the odd row reads it.
    always_ff @(posedge clk_i) begin
        if (w_lineWr)
            r_line[w_lineIdx] <= w_h;
    end

    assign bus.ready_o = w_ready;
    assign bus.data_o  = r_data;
    assign bus.valid_o = r_valid;
    assign bus.busy_o  = (r_state != IDLE);
    assign bus.done_o  = (r_state == DRAIN) & ~r_valid;
endmodule

// File: tb/tb_max_pool_2x2_stream.sv
// Self-checking bench: frame table driven through a scoreboard fed by a whole-frame reference model,
// plus hand sequences for reset, idle beats and mid-frame abort.
module tb_max_pool_2x2_stream;
    localparam int LANES    = 4;
    localparam int DATA_W   = 12;
    localparam int MAX_COLS = 64;
    localparam int MAX_ROWS = 64;
    localparam int W        = LANES * DATA_W;
    localparam int CW       = $clog2(MAX_COLS + 1);
    localparam int RW       = $clog2(MAX_ROWS + 1);

    typedef logic [W-1:0] word_t;
    typedef struct {
        int cols;
        int rows;
        bit maxEn;
        bit stall;
        int pattern;
        int expOuts;
    } frameVec_t;

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    always #5 clk_i = ~clk_i;

    max_pool_2x2_stream_if #(.LANES(LANES), .DATA_W(DATA_W), .MAX_COLS(MAX_COLS), .MAX_ROWS(MAX_ROWS)) bus ();

    max_pool_2x2_stream #(.LANES(LANES), .DATA_W(DATA_W), .MAX_COLS(MAX_COLS), .MAX_ROWS(MAX_ROWS)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    int        total = 0;
    int        bad   = 0;
    int        outCount  = 0;
    int        doneCount = 0;
    bit        stallMode  = 1'b0;
    bit        bypassMode = 1'b0;
    word_t     expQ [$];
    word_t     got  [$];
    word_t     pix  [256];
    frameVec_t vecs [8];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
        end
    endtask

    // Drive one beat, holding it until the DUT shows ready before an edge.
    task automatic applyStimulus(input word_t d, input int gap);
        bit acc;
        int n;
        repeat (gap) begin
            bus.valid_i = 1'b0;
            @(posedge clk_i); #1;
        end
        bus.valid_i = 1'b1;
        bus.data_i  = d;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge clk_i);
            acc = bus.ready_o;
            @(posedge clk_i); #1;
            n++;
        end
        if (!acc) checkOutput("accept_timeout", 64'(acc), 64'd1);
        bus.valid_i = 1'b0;
    endtask

    function automatic int clampDim(input int v, input int maxV);
        if (v == 0) return 1;
        if (v > maxV) return maxV;
        return v;
    endfunction

    task automatic fillPixels(input int ec, input int er, input int pattern);
        word_t w;
        for (int i = 0; i < ec * er; i++) begin
            w = W'({$urandom(), $urandom()});
            case (pattern)
                0: w[DATA_W-1:0] = DATA_W'((i / ec) * ec + (i % ec));
                2: begin
                    case (i)
                        0: w = {12'h123, 12'h8AB, 12'h800, 12'h7FF};
                        1: w = {12'h456, 12'h0AB, 12'h800, 12'h800};
                        2: w = {12'h456, 12'h0AB, 12'h800, 12'h000};
                        default: w = {12'h001, 12'h8AB, 12'h800, 12'h001};
                    endcase
                end
                3: w = {LANES{12'h001}};
                default: ;
            endcase
            pix[i] = w;
        end
    endtask

    // Whole-frame reference: window maxima computed directly from the stored frame.
    task automatic computeExpected(input int ec, input int er, input bit maxEn);
        word_t o, p;
        logic [DATA_W-2:0] m;
        if (!maxEn) begin
            for (int i = 0; i < ec * er; i++) expQ.push_back(pix[i]);
        end else begin
            for (int r2 = 0; r2 < er / 2; r2++) begin
                for (int c2 = 0; c2 < ec / 2; c2++) begin
                    o = '0;
                    for (int k = 0; k < LANES; k++) begin
                        m = '0;
                        for (int dr = 0; dr < 2; dr++) begin
                            for (int dc = 0; dc < 2; dc++) begin
                                p = pix[(2*r2 + dr) * ec + 2*c2 + dc];
                                if (p[k*DATA_W +: DATA_W-1] > m) m = p[k*DATA_W +: DATA_W-1];
                            end
                        end
                        o[k*DATA_W +: DATA_W] = {1'b0, m};
                    end
                    expQ.push_back(o);
                end
            end
        end
    endtask

    task automatic startFrame(input int cols, input int rows, input bit maxEn);
        bus.cfg_cols_i = CW'(cols);
        bus.cfg_rows_i = RW'(rows);
        bus.max_en_i   = maxEn;
        bus.start_i    = 1'b1;
        @(posedge clk_i); #1;
        bus.start_i    = 1'b0;
    endtask

    task automatic runFrame(input frameVec_t v);
        int ec, er, d0, n;
        ec = clampDim(v.cols, MAX_COLS);
        er = clampDim(v.rows, MAX_ROWS);
        fillPixels(ec, er, v.pattern);
        computeExpected(ec, er, v.maxEn);
        stallMode  = v.stall;
        bypassMode = !v.maxEn;
        outCount   = 0;
        got.delete();
        d0 = doneCount;
        startFrame(v.cols, v.rows, v.maxEn);
        for (int i = 0; i < ec * er; i++)
            applyStimulus(pix[i], (v.stall && (i % 3 == 1)) ? 1 : 0);
        n = 0;
        while (doneCount == d0 && n < 1000) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("done_seen", 64'(doneCount != d0), 64'd1);
        repeat (3) @(negedge clk_i);
        checkOutput("done_once", 64'(doneCount - d0), 64'd1);
        checkOutput("out_count", 64'(outCount), 64'(v.expOuts));
        checkOutput("sb_leftover", 64'(expQ.size()), 64'd0);
        checkOutput("busy_after", 64'(bus.busy_o), 64'd0);
        expQ.delete();
        stallMode  = 1'b0;
        bypassMode = 1'b0;
    endtask

    initial begin
        bus.ready_i = 1'b1;
        forever begin
            @(posedge clk_i); #1;
            bus.ready_i = stallMode ? ~bus.ready_i : 1'b1;
        end
    end

    // Output monitor: scoreboard pop on handshake, hold-while-stalled, bypass latency, done exclusivity.
    initial begin
        bit    prevStall = 1'b0;
        bit    prevAcc   = 1'b0;
        word_t prevData  = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                prevStall = 1'b0;
                prevAcc   = 1'b0;
            end else begin
                if (prevStall) begin
                    checkOutput("hold_valid", 64'(bus.valid_o), 64'd1);
                    checkOutput("hold_data", 64'(bus.data_o), 64'(prevData));
                end
                if (prevAcc) checkOutput("bypass_latency", 64'(bus.valid_o), 64'd1);
                if (bus.done_o) begin
                    doneCount++;
                    checkOutput("done_vs_valid", 64'(bus.valid_o), 64'd0);
                end
                if (bus.valid_o && bus.ready_i) begin
                    outCount++;
                    got.push_back(bus.data_o);
                    checkOutput("sb_nonempty", 64'(expQ.size() > 0), 64'd1);
                    if (expQ.size() > 0) checkOutput("data", 64'(bus.data_o), 64'(expQ.pop_front()));
                end
                prevStall = bus.valid_o & ~bus.ready_i;
                prevData  = bus.data_o;
                prevAcc   = bypassMode & bus.valid_i & bus.ready_o;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        word_t g;
        int    d0;
        int    lane0Exp [4] = '{5, 7, 13, 15};

        vecs[0] = '{cols: 4,   rows: 4, maxEn: 1'b1, stall: 1'b0, pattern: 0, expOuts: 4};
        vecs[1] = '{cols: 3,   rows: 2, maxEn: 1'b0, stall: 1'b0, pattern: 1, expOuts: 6};
        vecs[2] = '{cols: 4,   rows: 2, maxEn: 1'b1, stall: 1'b1, pattern: 1, expOuts: 2};
        vecs[3] = '{cols: 5,   rows: 3, maxEn: 1'b1, stall: 1'b0, pattern: 1, expOuts: 2};
        vecs[4] = '{cols: 2,   rows: 2, maxEn: 1'b1, stall: 1'b0, pattern: 2, expOuts: 1};
        vecs[5] = '{cols: 0,   rows: 3, maxEn: 1'b1, stall: 1'b0, pattern: 1, expOuts: 0};
        vecs[6] = '{cols: 100, rows: 2, maxEn: 1'b1, stall: 1'b0, pattern: 1, expOuts: 32};
        vecs[7] = '{cols: 6,   rows: 4, maxEn: 1'b0, stall: 1'b1, pattern: 1, expOuts: 24};

        bus.start_i    = 1'b0;
        bus.cfg_cols_i = '0;
        bus.cfg_rows_i = '0;
        bus.max_en_i   = 1'b0;
        bus.data_i     = '0;
        bus.valid_i    = 1'b0;

        #12;
        checkOutput("rst_ready", 64'(bus.ready_o), 64'd0);
        checkOutput("rst_valid", 64'(bus.valid_o), 64'd0);
        checkOutput("rst_data", 64'(bus.data_o), 64'd0);
        checkOutput("rst_busy", 64'(bus.busy_o), 64'd0);
        checkOutput("rst_done", 64'(bus.done_o), 64'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        $display("[TB] idle beats must be refused");
        bus.valid_i = 1'b1;
        bus.data_i  = {LANES{12'hABC}};
        repeat (3) begin
            @(negedge clk_i);
            checkOutput("idle_ready", 64'(bus.ready_o), 64'd0);
        end
        @(posedge clk_i); #1;
        bus.valid_i = 1'b0;
        checkOutput("idle_no_output", 64'(outCount), 64'd0);

        for (int i = 0; i < 8; i++) begin
            $display("[TB] frame %0d: %0dx%0d maxEn=%0d stall=%0d", i, vecs[i].cols, vecs[i].rows, vecs[i].maxEn, vecs[i].stall);
            runFrame(vecs[i]);
            if (i == 0) begin
                for (int j = 0; j < 4; j++) begin
                    g = got[j];
                    checkOutput("lane0_4x4", 64'(g[DATA_W-1:0]), 64'(lane0Exp[j]));
                end
            end
            if (i == 4) begin
                g = got[0];
                checkOutput("lane_msb", 64'(g), 64'({12'h456, 12'h0AB, 12'h000, 12'h7FF}));
            end
        end

        $display("[TB] mid-frame reset during 8x8 pool");
        fillPixels(8, 8, 1);
        computeExpected(8, 8, 1'b1);
        d0 = doneCount;
        startFrame(8, 8, 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus(pix[i], 0);
        #2;
        rst_n_i = 1'b0;
        #1;
        checkOutput("abort_ready", 64'(bus.ready_o), 64'd0);
        checkOutput("abort_valid", 64'(bus.valid_o), 64'd0);
        checkOutput("abort_busy", 64'(bus.busy_o), 64'd0);
        checkOutput("abort_data", 64'(bus.data_o), 64'd0);
        expQ.delete();
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (3) @(negedge clk_i);
        checkOutput("abort_no_done", 64'(doneCount - d0), 64'd0);
        runFrame('{cols: 2, rows: 2, maxEn: 1'b1, stall: 1'b0, pattern: 3, expOuts: 1});
        g = got[0];
        checkOutput("after_abort", 64'(g), 64'({LANES{12'h001}}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
